game_event_gen: RTL and testbench
=================================

# game_event_gen

Event producer for the game state controller: turns raw keyboard keycodes, collision hits and the frame tick into the single-cycle `game_enter`, `game_exit` and `game_start` request pulses that the controller consumes. It also owns the lives counter, the post-hit invulnerability cooldown and the game-over hold timer. It sits between the USB keyboard / collision logic and the state controller, and reads `game_state` back as the acknowledge for each request.

## Interface
- `KEY_ENTER`, 8'h28, keycode that requests enter (Enter).
- `KEY_START`, 8'h2C, keycode that requests a restart (Space).
- `KEY_QUIT`, 8'h29, keycode that requests quit (Escape); used only with the quit feature.
- `LIVES`, 3, lives loaded at game entry; legal range 1..7.
- `HIT_COOLDOWN`, 60, frame ticks of invulnerability after a hit; legal range 0..255.
- `POST_HOLD`, 120, frame ticks in post_game before a restart is accepted; legal range 0..255.

Ports:
- `Clk` in 1: system clock. One clock domain only.
- `Reset` in 1: asynchronous, active-high reset.
- `keycode` in 8: current keyboard keycode; 8'h00 means no key.
- `player_hit` in 1: collision level from game logic.
- `frame_tick` in 1: one-cycle pulse, once per frame.
- `game_state` in 2: controller state. 00 = pre_game, 01 = in_game, 10 = post_game.
- `game_enter` out 1: one-cycle request pulse.
- `game_exit` out 1: one-cycle request pulse.
- `game_start` out 1: one-cycle request pulse.
- `lives` out 3: remaining lives.
- `invuln` out 1: high while the cooldown counter is non-zero.

## Operation
- **Edge detection**
  - The registers `enter_q`, `start_q`, `quit_q` and `hit_q` hold the previous-cycle match or level for each input.
  - An event is defined as current match AND NOT previous match.
  - A key held down produces exactly one event.
- **FSM states:** TITLE, PLAY, HOLD, READY, WAIT_ACK. WAIT_ACK latches `ack_state`, the `game_state` value expected after the request.
- **TITLE** (requires `game_state`=00)
  - Enter event: pulse `game_enter`, load `lives`=LIVES, clear cooldown, go to WAIT_ACK with expected state 01.
  - Return state after acknowledge: PLAY.
- **PLAY**
  - A hit event with cooldown=0 decrements `lives` and loads cooldown=HIT_COOLDOWN.
  - A hit event with cooldown≠0 is ignored.
  - The cooldown check uses the cooldown value before any same-cycle frame_tick decrement.
  - When a decrement takes `lives` 1→0: pulse `game_exit`, go to WAIT_ACK with expected state 10. Return state: HOLD.
- **HOLD**
  - On entry, the hold counter is loaded with POST_HOLD.
  - The counter decrements on each frame_tick.
  - When it reaches 0, go to READY. With POST_HOLD=0, go to READY on the next cycle.
  - Keycodes are ignored in HOLD.
- **READY:** Start event: pulse `game_start`, go to WAIT_ACK with expected state 00. Return state: TITLE.
- **WAIT_ACK**
  - No pulses are generated and events are discarded.
  - Leave to the return state when `game_state` equals the expected state.
- **Resync:** in any non-WAIT_ACK state, if `game_state` disagrees with the state's required value, jump to the matching state.
  - 00 → TITLE.
  - 01 → PLAY.
  - 10 → HOLD, with the hold counter reloaded.
  - 11 → TITLE, with no pulses.
- **Cooldown:** an 8-bit counter that decrements on frame_tick while non-zero, saturating at 0. It is active in PLAY only and cleared in all other states.
- **Pulse rule:** at most one pulse output is high in any cycle.

## Timing
- **Reset values:**
  - All pulse outputs 0, `invuln`=0, `lives`=LIVES.
  - FSM in TITLE; all counters and edge registers 0.
- **Pulse latency:** an event sampled at edge N drives its pulse high for exactly cycle N+1. Outputs are registered.
- **Acknowledge:** the controller updates `game_state` one cycle after the pulse, so WAIT_ACK normally lasts 1 cycle. There is no timeout.
- **Lives:** `lives` updates on the same edge as the pulse, or on the hit edge when no exit results.
- **Hold count:** the hold counter reaches 0 exactly POST_HOLD frame ticks after HOLD entry.
- **Mid-operation reset:** asserting `Reset` mid-operation immediately returns all state to the reset values, including during WAIT_ACK. No partial pulse is emitted.

## Configuration
- `GAME_EVT_QUIT_KEY_EN`
  - **Defined:** in PLAY, a KEY_QUIT event pulses `game_exit` and goes to WAIT_ACK with expected state 10, leaving `lives` unchanged.
    - If a quit event and a hit event occur in the same cycle, a single `game_exit` pulse is issued and the lives decrement still applies.
  - **Undefined:** KEY_QUIT is ignored, `quit_q` and its logic are absent, and lives exhaustion is the only exit.

## Test plan
- **Enter and acknowledge:** reset, hold `game_state`=00, hold `keycode`=28 for 10 cycles → exactly one `game_enter` pulse one cycle after the first match, and `lives`=3. Then drive `game_state`=01 → FSM reaches PLAY.
- **Cooldown:** with HIT_COOLDOWN=2, in PLAY, apply a hit, then hit again after 1 frame_tick, then again after 2 frame_ticks.
  - Response: `lives` 3→2, unchanged after the second hit, then 2→1.
  - `invuln` is high for exactly 2 ticks.
- **Exhaustion:** the third valid hit takes `lives` to 0 → `game_exit` pulse. Returning `game_state`=10 → HOLD entered.
- **Hold then restart:** with POST_HOLD=3, press Space before the 3rd frame_tick → no pulse. Press Space after it → one `game_start` pulse. `game_state`=00 → TITLE.
- **Mid-operation reset:** assert `Reset` asynchronously during WAIT_ACK → outputs 0 immediately, `lives`=LIVES, FSM in TITLE.
- **Quit key (macro defined):** Escape and `player_hit` in the same cycle in PLAY → one `game_exit` pulse and `lives` decremented by 1. With the macro undefined, Escape alone → no pulse.

Source files
------------

// File: rtl/game_event_gen.sv
// game_event_gen: turns keycodes, collision hits and the frame tick into
// single-cycle enter/exit/start requests for the game state controller.
// It also owns the lives counter, the post-hit cooldown and the game-over
// hold timer.
// Optional feature: define GAME_EVT_QUIT_KEY_EN to let KEY_QUIT end a game.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// TITLE    | pre_game, waiting for an Enter press
// PLAY     | in_game, counting hits and running the cooldown
// HOLD     | post_game, hold timer running, keys ignored
// READY    | post_game, hold expired, waiting for a Space press
// WAIT_ACK | request issued, waiting for game_state to equal ack_state
module game_event_gen #(
`ifdef GAME_EVT_QUIT_KEY_EN
  parameter logic [7:0]  KEY_QUIT     = 8'h29,
`endif
  parameter logic [7:0]  KEY_ENTER    = 8'h28,
  parameter logic [7:0]  KEY_START    = 8'h2C,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned HIT_COOLDOWN = 60,
  parameter int unsigned POST_HOLD    = 120
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       player_hit,
  input  logic       frame_tick,
  input  logic [1:0] game_state,
  output logic       game_enter,
  output logic       game_exit,
  output logic       game_start,
  output logic [2:0] lives,
  output logic       invuln
);

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] HIT_CD     = 8'(HIT_COOLDOWN);
  localparam logic [7:0] HOLD_INIT  = 8'(POST_HOLD);

  localparam logic [1:0] GS_PRE  = 2'b00;
  localparam logic [1:0] GS_IN   = 2'b01;
  localparam logic [1:0] GS_POST = 2'b10;

  typedef enum logic [2:0] {
    S_TITLE,
    S_PLAY,
    S_HOLD,
    S_READY,
    S_WAIT_ACK
  } state_t;

  state_t     state;
  state_t     ret_state;
  logic [1:0] ack_state;
  logic [7:0] cooldown;
  logic [7:0] hold_cnt;

  logic enter_q;
  logic start_q;
  logic hit_q;

  logic enter_evt;
  logic start_evt;
  logic hit_evt;
  logic hit_take;
  logic exit_req;
  logic [1:0] req_gs;
  logic resync;

  assign enter_evt = (keycode == KEY_ENTER) & ~enter_q;
  assign start_evt = (keycode == KEY_START) & ~start_q;
  assign hit_evt   = player_hit & ~hit_q;

  // A hit only counts when the cooldown (pre-tick value) has expired.
  assign hit_take  = hit_evt & (cooldown == 8'd0) & (lives != 3'd0);

`ifdef GAME_EVT_QUIT_KEY_EN
  logic quit_q;
  logic quit_evt;

  assign quit_evt = (keycode == KEY_QUIT) & ~quit_q;

  // Previous-cycle quit key match for edge detection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) quit_q <= 1'b0;
    else       quit_q <= (keycode == KEY_QUIT);
  end

  assign exit_req = (hit_take & (lives == 3'd1)) | quit_evt;
`else
  assign exit_req = hit_take & (lives == 3'd1);
`endif

  assign invuln = (cooldown != 8'd0);

  // game_state value each stable state expects from the controller.
  always_comb begin
    req_gs = GS_PRE;
    case (state)
      S_PLAY:          req_gs = GS_IN;
      S_HOLD, S_READY: req_gs = GS_POST;
      default:         req_gs = GS_PRE;
    endcase
  end

  assign resync = (state != S_WAIT_ACK) && (game_state != req_gs);

  // Previous-cycle key matches and hit level for edge detection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      enter_q <= 1'b0;
      start_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      enter_q <= (keycode == KEY_ENTER);
      start_q <= (keycode == KEY_START);
      hit_q   <= player_hit;
    end
  end

  // Main sequencer: request pulses, lives, cooldown and hold timer.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_TITLE;
      ret_state  <= S_TITLE;
      ack_state  <= GS_PRE;
      cooldown   <= 8'd0;
      hold_cnt   <= 8'd0;
      lives      <= LIVES_INIT;
      game_enter <= 1'b0;
      game_exit  <= 1'b0;
      game_start <= 1'b0;
    end else begin
      game_enter <= 1'b0;
      game_exit  <= 1'b0;
      game_start <= 1'b0;

      if (resync) begin
        // Controller disagrees with us: follow it silently.
        cooldown <= 8'd0;
        case (game_state)
          GS_IN:   state <= S_PLAY;
          GS_POST: begin
            state    <= S_HOLD;
            hold_cnt <= HOLD_INIT;
          end
          default: state <= S_TITLE;
        endcase
      end else begin
        case (state)
          S_TITLE: begin
            cooldown <= 8'd0;
            if (enter_evt) begin
              game_enter <= 1'b1;
              lives      <= LIVES_INIT;
              ack_state  <= GS_IN;
              ret_state  <= S_PLAY;
              state      <= S_WAIT_ACK;
            end
          end

          S_PLAY: begin
            if (hit_take) begin
              lives    <= lives - 3'd1;
              cooldown <= HIT_CD;
            end else if (frame_tick && (cooldown != 8'd0)) begin
              cooldown <= cooldown - 8'd1;
            end
            if (exit_req) begin
              game_exit <= 1'b1;
              cooldown  <= 8'd0;
              ack_state <= GS_POST;
              ret_state <= S_HOLD;
              state     <= S_WAIT_ACK;
            end
          end

          S_HOLD: begin
            cooldown <= 8'd0;
            if (hold_cnt == 8'd0) begin
              state <= S_READY;
            end else if (frame_tick) begin
              hold_cnt <= hold_cnt - 8'd1;
              if (hold_cnt == 8'd1) state <= S_READY;
            end
          end

          S_READY: begin
            cooldown <= 8'd0;
            if (start_evt) begin
              game_start <= 1'b1;
              ack_state  <= GS_PRE;
              ret_state  <= S_TITLE;
              state      <= S_WAIT_ACK;
            end
          end

          S_WAIT_ACK: begin
            cooldown <= 8'd0;
            if (game_state == ack_state) begin
              state <= ret_state;
              if (ret_state == S_HOLD) hold_cnt <= HOLD_INIT;
            end
          end

          default: state <= S_TITLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_event_gen.sv
`timescale 1ns/1ps
// Bench for game_event_gen: a phase-level reference model checked every
// cycle, plus hand-computed literal checks along a directed scenario.
module tb_game_event_gen;

  localparam int LIV = 3;
  localparam int HCD = 2;
  localparam int PHD = 3;

  localparam int PH_TITLE = 0;
  localparam int PH_PLAY  = 1;
  localparam int PH_POST  = 2;
  localparam int PH_READY = 3;
  localparam int PH_ACK   = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       player_hit;
  logic       frame_tick;
  logic [1:0] game_state;
  logic       game_enter;
  logic       game_exit;
  logic       game_start;
  logic [2:0] lives;
  logic       invuln;

  int checks = 0;
  int errors = 0;
  int n_enter = 0;
  int n_exit = 0;
  int n_start = 0;

  // model state
  int m_phase, m_back, m_want, m_lives, m_cd, m_hold;
  bit p_ent, p_sta, p_qui, p_hit;
  bit x_enter, x_exit, x_start;

  game_event_gen #(
    .HIT_COOLDOWN(HCD),
    .POST_HOLD   (PHD)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .player_hit(player_hit),
    .frame_tick(frame_tick),
    .game_state(game_state),
    .game_enter(game_enter),
    .game_exit (game_exit),
    .game_start(game_start),
    .lives     (lives),
    .invuln    (invuln)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_TITLE; m_back = PH_TITLE; m_want = 0;
    m_lives = LIV; m_cd = 0; m_hold = 0;
    p_ent = 0; p_sta = 0; p_qui = 0; p_hit = 0;
    x_enter = 0; x_exit = 0; x_start = 0;
  endtask

  task automatic model_step();
    bit e, s, q, h, take, quitting;
    int need;
    e = (keycode == 8'h28) && !p_ent;
    s = (keycode == 8'h2C) && !p_sta;
    q = (keycode == 8'h29) && !p_qui;
    h = player_hit && !p_hit;
    p_ent = (keycode == 8'h28);
    p_sta = (keycode == 8'h2C);
    p_qui = (keycode == 8'h29);
    p_hit = player_hit;
    x_enter = 0; x_exit = 0; x_start = 0;
    quitting = 0;
`ifdef GAME_EVT_QUIT_KEY_EN
    quitting = q;
`endif
    if (m_phase == PH_PLAY) need = 1;
    else if (m_phase == PH_POST || m_phase == PH_READY) need = 2;
    else need = 0;
    if (m_phase != PH_ACK && int'(game_state) != need) begin
      m_cd = 0;
      if (game_state == 2'b01) m_phase = PH_PLAY;
      else if (game_state == 2'b10) begin m_phase = PH_POST; m_hold = PHD; end
      else m_phase = PH_TITLE;
    end else begin
      case (m_phase)
        PH_TITLE: if (e) begin
          x_enter = 1; m_lives = LIV; m_cd = 0;
          m_want = 1; m_back = PH_PLAY; m_phase = PH_ACK;
        end
        PH_PLAY: begin
          take = h && m_cd == 0 && m_lives > 0;
          if (take) begin m_lives = m_lives - 1; m_cd = HCD; end
          else if (frame_tick && m_cd > 0) m_cd = m_cd - 1;
          if ((take && m_lives == 0) || quitting) begin
            x_exit = 1; m_cd = 0;
            m_want = 2; m_back = PH_POST; m_phase = PH_ACK;
          end
        end
        PH_POST: begin
          if (m_hold == 0) m_phase = PH_READY;
          else if (frame_tick) begin
            m_hold = m_hold - 1;
            if (m_hold == 0) m_phase = PH_READY;
          end
        end
        PH_READY: if (s) begin
          x_start = 1; m_want = 0; m_back = PH_TITLE; m_phase = PH_ACK;
        end
        default: if (int'(game_state) == m_want) begin
          m_phase = m_back;
          if (m_back == PH_POST) m_hold = PHD;
        end
      endcase
    end
  endtask

  // Advance the model on every edge (or async reset) and compare shortly after.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) model_reset();
    else model_step();
    #1;
    check("pulses", int'({game_enter, game_exit, game_start}),
          int'({x_enter, x_exit, x_start}));
    check("lives", int'(lives), m_lives);
    check("invuln", int'(invuln), int'(m_cd != 0));
    check("one_pulse", int'($countones({game_enter, game_exit, game_start}) <= 1), 1);
    n_enter += int'(game_enter);
    n_exit  += int'(game_exit);
    n_start += int'(game_start);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected scenario end");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic hit();
    player_hit = 1'b1; @(negedge Clk);
    player_hit = 1'b0; @(negedge Clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1; @(negedge Clk);
    frame_tick = 1'b0; @(negedge Clk);
  endtask

  initial begin
    int exits_before;
    Reset = 1'b1; keycode = 8'h00; player_hit = 1'b0;
    frame_tick = 1'b0; game_state = 2'b00;
    repeat (2) @(negedge Clk);
    check("rst_lives", int'(lives), 3);
    check("rst_pulses", int'({game_enter, game_exit, game_start}), 0);
    check("rst_invuln", int'(invuln), 0);
    Reset = 1'b0;
    @(negedge Clk);

    // Enter held for 10 cycles: one pulse, controller slow to ack.
    keycode = 8'h28;
    repeat (10) @(negedge Clk);
    check("enter_count", n_enter, 1);
    check("enter_lives", int'(lives), 3);
    keycode = 8'h00; game_state = 2'b01;
    repeat (2) @(negedge Clk);

    // Cooldown behaviour.
    hit();
    check("hit1_lives", int'(lives), 2);
    check("hit1_invuln", int'(invuln), 1);
    tick();
    check("cd_tick1_invuln", int'(invuln), 1);
    hit();
    check("hit2_ignored", int'(lives), 2);
    tick();
    check("cd_tick2_invuln", int'(invuln), 0);
    hit();
    check("hit3_lives", int'(lives), 1);
    tick(); tick();
    hit();
    check("exhaust_exit", n_exit, 1);
    check("exhaust_lives", int'(lives), 0);
    game_state = 2'b10;
    repeat (2) @(negedge Clk);

    // Hold then restart.
    tick();
    keycode = 8'h2C; @(negedge Clk);
    keycode = 8'h00; @(negedge Clk);
    tick(); tick();
    check("hold_no_start", n_start, 0);
    keycode = 8'h2C;
    repeat (3) @(negedge Clk);
    keycode = 8'h00;
    check("start_count", n_start, 1);
    game_state = 2'b00;
    repeat (2) @(negedge Clk);

    // Second game, reset during the exit WAIT_ACK.
    keycode = 8'h28; @(negedge Clk);
    keycode = 8'h00; game_state = 2'b01; @(negedge Clk);
    check("enter2_count", n_enter, 2);
    hit(); tick(); tick(); hit(); tick(); tick();
    player_hit = 1'b1; @(negedge Clk);
    player_hit = 1'b0;
    check("exit2_pulse", int'(game_exit), 1);
    check("exit2_lives", int'(lives), 0);
    #2 Reset = 1'b1;
    #1;
    check("arst_exit", int'(game_exit), 0);
    check("arst_lives", int'(lives), 3);
    check("arst_invuln", int'(invuln), 0);
    game_state = 2'b00;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    keycode = 8'h28; @(negedge Clk);
    keycode = 8'h00;
    check("post_rst_enter", int'(game_enter), 1);
    game_state = 2'b01;
    repeat (2) @(negedge Clk);

    // Quit key.
    exits_before = n_exit;
`ifdef GAME_EVT_QUIT_KEY_EN
    keycode = 8'h29; player_hit = 1'b1; @(negedge Clk);
    keycode = 8'h00; player_hit = 1'b0;
    check("quit_hit_exit", int'(game_exit), 1);
    check("quit_hit_lives", int'(lives), 2);
    @(negedge Clk);
    check("quit_hit_count", n_exit - exits_before, 1);
    game_state = 2'b10;
    repeat (2) @(negedge Clk);
`else
    keycode = 8'h29;
    repeat (3) @(negedge Clk);
    keycode = 8'h00;
    check("quit_ignored", n_exit - exits_before, 0);
    check("quit_lives", int'(lives), 3);
    hit();
    check("play_after_esc", int'(lives), 2);
`endif
    repeat (2) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
